// File: rtl/lcd_pkg.sv
// Shared definitions for the KC705 character-LCD engines.
// Holds the read FSM state encoding, the default 200 MHz sys0 timing, and the RS encodings.
package lcd_pkg;

    // Read engine phases, in the order one read cycle walks through them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EH1   = 3'd2,
        ST_EL1   = 3'd3,
        ST_EH2   = 3'd4,
        ST_HOLD  = 3'd5,
        ST_RESP  = 3'd6
    } rd_state_e;

    // Default LCD bus timing in sys0_clk cycles (5 ns period).
    localparam int LCD_T_AS = 8;    // RS/RW setup before E rise (40 ns)
    localparam int LCD_T_EH = 50;   // E high per nibble (250 ns), covers tDDR plus sync delay
    localparam int LCD_T_EL = 100;  // E low between nibbles (500 ns)
    localparam int LCD_T_AH = 4;    // RS/RW hold after last E fall (20 ns)

    // Register select encodings.
    localparam logic RS_CMD  = 1'b0;  // busy flag / address counter
    localparam logic RS_DATA = 1'b1;  // DDRAM / CGRAM data

endpackage

// File: rtl/lcd_nibble_reader_if.sv
// Request/response channel of the LCD read engine.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The sender holds valid and its payload stable until that
// edge; ready may be high before valid rises and may depend on nothing else.
// Request channel: req_valid/req_ready carry req_rs.
// Response channel: rsp_valid/rsp_ready carry rsp_data and rsp_busy.
interface lcd_nibble_reader_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_busy;

    // Requester side: issues reads and consumes responses.
    modport master (
        output req_valid, req_rs, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_busy
    );

    // Reader side: accepts reads and produces responses.
    modport slave (
        input  req_valid, req_rs, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_busy
    );
endinterface

// File: rtl/lcd_nibble_reader_sync2_bus.sv
// Two-flop synchronizer for a slow multi-bit bus that is only sampled once
// it has been stable for many cycles (LCD data pins during a long E pulse).
module sync2_bus #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two register stages to let the first stage settle out of metastability.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/lcd_nibble_reader.sv
// Read-side engine for the HD44780-style LCD in 4-bit mode.
// Performs one RW=1 cycle as two E strobes, high nibble first, and returns
// the assembled byte on the response channel. While bus_own is high the top
// level routes lcd_e/lcd_rs/lcd_rw from here and tristates the data pins.
module lcd_nibble_reader
    import lcd_pkg::*;
#(
    parameter int T_AS = LCD_T_AS,
    parameter int T_EH = LCD_T_EH,
    parameter int T_EL = LCD_T_EL,
    parameter int T_AH = LCD_T_AH,
    parameter int CW   = 8          // all timing values must fit in 1..2^CW-1
) (
    input  logic                      sys0_clk,
    input  logic                      sys0_rstn,
    lcd_nibble_reader_if.slave        rd,
    input  logic [3:0]                lcd_db_i,
    output logic                      lcd_e,
    output logic                      lcd_rs,
    output logic                      lcd_rw,
    output logic                      bus_own,
    output rd_state_e                 dbg_state_o
);
    localparam logic [CW-1:0] LD_AS = CW'(T_AS - 1);
    localparam logic [CW-1:0] LD_EH = CW'(T_EH - 1);
    localparam logic [CW-1:0] LD_EL = CW'(T_EL - 1);
    localparam logic [CW-1:0] LD_AH = CW'(T_AH - 1);

    logic [3:0] db_sync;

    rd_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          rs_q;
    logic [7:0]    rsp_data_q;
    logic          rsp_busy_q;
    logic          rsp_valid_q;
    logic          req_ready_q;
    logic          bus_own_q;
    logic          lcd_e_q;
    logic          lcd_rs_q;
    logic          lcd_rw_q;

    sync2_bus #(.W(4)) u_db_sync (
        .clk  (sys0_clk),
        .rstn (sys0_rstn),
        .d_i  (lcd_db_i),
        .q_o  (db_sync)
    );

    // Read-cycle sequencer: each phase loads length-1 and advances when the counter hits zero.
    always_ff @(posedge sys0_clk) begin
        if (!sys0_rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rs_q        <= RS_CMD;
            rsp_data_q  <= '0;
            rsp_busy_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            bus_own_q   <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_rw_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rd.req_valid && req_ready_q) begin
                        rs_q        <= rd.req_rs;
                        lcd_rs_q    <= rd.req_rs;
                        lcd_rw_q    <= 1'b1;
                        bus_own_q   <= 1'b1;
                        req_ready_q <= 1'b0;
                        cnt_q       <= LD_AS;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        lcd_e_q <= 1'b1;
                        cnt_q   <= LD_EH;
                        state_q <= ST_EH1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_EH1: begin
                    if (cnt_q == '0) begin
                        rsp_data_q[7:4] <= db_sync;
                        lcd_e_q         <= 1'b0;
                        cnt_q           <= LD_EL;
                        state_q         <= ST_EL1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_EL1: begin
                    if (cnt_q == '0) begin
                        lcd_e_q <= 1'b1;
                        cnt_q   <= LD_EH;
                        state_q <= ST_EH2;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_EH2: begin
                    if (cnt_q == '0) begin
                        rsp_data_q[3:0] <= db_sync;
                        lcd_e_q         <= 1'b0;
                        cnt_q           <= LD_AH;
                        state_q         <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        lcd_rw_q    <= 1'b0;
                        lcd_rs_q    <= 1'b0;
                        bus_own_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        // Only a command read carries the busy flag in bit 7.
                        rsp_busy_q  <= (rs_q == RS_CMD) ? rsp_data_q[7] : 1'b0;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rd.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd.req_ready  = req_ready_q;
    assign rd.rsp_valid  = rsp_valid_q;
    assign rd.rsp_data   = rsp_data_q;
    assign rd.rsp_busy   = rsp_busy_q;
    assign bus_own       = bus_own_q;
    assign lcd_e         = lcd_e_q;
    assign lcd_rs        = lcd_rs_q;
    assign lcd_rw        = lcd_rw_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_lcd_nibble_reader.sv
// Bench for lcd_nibble_reader: LCD read model, protocol monitor, vector table
// and hand-written multi-cycle sequences.
module tb_lcd_nibble_reader;
    import lcd_pkg::*;

    localparam int TDDR = 32;    // LCD data-out delay after E rise (160 ns)
    localparam int LAT  = 212;   // acceptance to first rsp_valid

    // ---------------- clock / reset ----------------
    logic sys0_clk  = 1'b0;
    logic sys0_rstn = 1'b0;
    always #5 sys0_clk = ~sys0_clk;

    int cyc = 0;
    always @(posedge sys0_clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    lcd_nibble_reader_if rd();
    logic [3:0] lcd_db_i = 4'hF;
    logic       lcd_e, lcd_rs, lcd_rw, bus_own;
    rd_state_e  dbg_state;

    lcd_nibble_reader dut (
        .sys0_clk    (sys0_clk),
        .sys0_rstn   (sys0_rstn),
        .rd          (rd),
        .lcd_db_i    (lcd_db_i),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .bus_own     (bus_own),
        .dbg_state_o (dbg_state)
    );

    // ---------------- LCD model ----------------
    logic [3:0] m_hi = 4'hF;
    logic [3:0] m_lo = 4'hF;
    logic       m_e_prev = 1'b0;
    logic       m_idx = 1'b0;
    int         m_dcnt = 0;

    always @(posedge sys0_clk) begin
        m_e_prev <= lcd_e;
        if (bus_own !== 1'b1) begin
            m_idx    <= 1'b0;
            m_dcnt   <= 0;
            lcd_db_i <= 4'hF;
        end else begin
            if (lcd_e && !m_e_prev && lcd_rw) begin
                m_dcnt   <= TDDR;
                lcd_db_i <= 4'hF;
            end else if (m_dcnt == 1) begin
                lcd_db_i <= m_idx ? m_lo : m_hi;
                m_dcnt   <= 0;
            end else if (m_dcnt != 0) begin
                m_dcnt <= m_dcnt - 1;
            end
            if (!lcd_e && m_e_prev) m_idx <= 1'b1;
        end
    end

    // ---------------- protocol monitor ----------------
    logic e_mon = 1'b0, own_mon = 1'b0, rs_mon = 1'b0, rw_mon = 1'b0, v_mon = 1'b0;
    int   last_fall = 0, gap_last = 0, proto_err = 0, valid_rises = 0;

    always @(negedge sys0_clk) begin
        if (lcd_e === 1'b1 && e_mon === 1'b0) gap_last <= cyc - last_fall;
        if (lcd_e === 1'b0 && e_mon === 1'b1) last_fall <= cyc;
        if (lcd_e === 1'b1 && (lcd_rw !== 1'b1 || bus_own !== 1'b1)) proto_err <= proto_err + 1;
        if (bus_own === 1'b1 && own_mon === 1'b1 && (lcd_rs !== rs_mon || lcd_rw !== rw_mon))
            proto_err <= proto_err + 1;
        if (rd.rsp_valid === 1'b1 && v_mon !== 1'b1) valid_rises <= valid_rises + 1;
        e_mon   <= lcd_e;
        own_mon <= bus_own;
        rs_mon  <= lcd_rs;
        rw_mon  <= lcd_rw;
        v_mon   <= rd.rsp_valid;
    end

    // ---------------- scoreboard / checks ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    int   acc_cyc = 0;
    int   lat = 0;
    int   t_err = 0;
    logic rs_mid = 1'b0;
    int   gap_mid = 0;

    // Present a request at the current negedge and wait for acceptance.
    task automatic start_req(input logic rs);
        int t;
        t = 0;
        rd.req_valid = 1'b1;
        rd.req_rs    = rs;
        while (rd.req_ready !== 1'b1 && t < 1000) begin
            @(negedge sys0_clk);
            t++;
        end
        if (t >= 1000) check("req_accept_timeout", 32'(t), 32'd0);
        acc_cyc = cyc + 1;
        @(negedge sys0_clk);
        rd.req_valid = 1'b0;
        rd.req_rs    = ~rs;   // req_rs wiggling after acceptance must not matter
    endtask

    // Wait for rsp_valid; optionally check E/RW waveform against the nominal schedule.
    task automatic wait_rsp(input bit chk_timing);
        int n, rel;
        logic exp_e, exp_rw;
        n = 0;
        t_err = 0;
        while (rd.rsp_valid !== 1'b1 && n < 2000) begin
            rel = cyc - acc_cyc;
            if (rel == 100) rs_mid = lcd_rs;
            if (rel == 20) gap_mid = gap_last;
            if (chk_timing) begin
                exp_e  = (rel >= 8 && rel <= 57) || (rel >= 158 && rel <= 207);
                exp_rw = (rel <= 211);
                if (lcd_e !== exp_e || lcd_rw !== exp_rw || bus_own !== exp_rw) t_err++;
            end
            @(negedge sys0_clk);
            n++;
        end
        if (n >= 2000) check("rsp_valid_timeout", 32'(n), 32'd0);
        lat = cyc - acc_cyc;
    endtask

    // Complete the response handshake and check the return to IDLE.
    task automatic finish_rsp(input string tag);
        rd.rsp_ready = 1'b1;
        @(negedge sys0_clk);
        rd.rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(rd.rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(rd.req_ready), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rs;
        logic [3:0] hi;
        logic [3:0] lo;
        logic [7:0] exp_data;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] exp_q[$];

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int   errs, rises0, d;
        logic rs_r;
        logic [3:0] hi_r, lo_r;

        vecs[0] = '{rs: 1'b0, hi: 4'h8, lo: 4'h3, exp_data: 8'h83, exp_busy: 1'b1};
        vecs[1] = '{rs: 1'b1, hi: 4'h4, lo: 4'h1, exp_data: 8'h41, exp_busy: 1'b0};
        vecs[2] = '{rs: 1'b0, hi: 4'h0, lo: 4'h5, exp_data: 8'h05, exp_busy: 1'b0};
        vecs[3] = '{rs: 1'b1, hi: 4'hF, lo: 4'h0, exp_data: 8'hF0, exp_busy: 1'b0};
        vecs[4] = '{rs: 1'b0, hi: 4'hC, lo: 4'hF, exp_data: 8'hCF, exp_busy: 1'b1};
        vecs[5] = '{rs: 1'b1, hi: 4'hA, lo: 4'h5, exp_data: 8'hA5, exp_busy: 1'b0};

        rd.req_valid = 1'b0;
        rd.req_rs    = 1'b0;
        rd.rsp_ready = 1'b0;

        // Reset values while reset is held.
        repeat (4) @(negedge sys0_clk);
        check("rst_req_ready", 32'(rd.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rd.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(rd.rsp_data),  32'd0);
        check("rst_rsp_busy",  32'(rd.rsp_busy),  32'd0);
        check("rst_lcd_pins",  32'({bus_own, lcd_e, lcd_rs, lcd_rw}), 32'd0);
        check("rst_state",     32'(dbg_state), 32'(ST_IDLE));

        // Idle with the bus floating high: nothing happens.
        sys0_rstn = 1'b1;
        repeat (40) @(negedge sys0_clk);
        check("idle_no_valid", 32'(valid_rises), 32'd0);
        check("idle_pins", 32'({bus_own, lcd_e, lcd_rw, rd.req_ready}), 32'b0001);

        // Command read with full waveform timing check.
        m_hi = 4'h8; m_lo = 4'h3;
        start_req(RS_CMD);
        wait_rsp(1'b1);
        check("t1_latency", 32'(lat), 32'(LAT));
        check("t1_waveform_errs", 32'(t_err), 32'd0);
        check("t1_data", 32'(rd.rsp_data), 32'h83);
        check("t1_busy", 32'(rd.rsp_busy), 32'd1);
        check("t1_pins_released", 32'({bus_own, lcd_e, lcd_rw, lcd_rs}), 32'd0);
        finish_rsp("t1");

        // Table of reads: expected bytes go through the scoreboard queue.
        for (int i = 0; i < 6; i++) begin
            m_hi = vecs[i].hi; m_lo = vecs[i].lo;
            exp_q.push_back(vecs[i].exp_data);
            repeat (3) @(negedge sys0_clk);
            start_req(vecs[i].rs);
            wait_rsp(1'b0);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("vec%0d_rs_mid", i), 32'(rs_mid), 32'(vecs[i].rs));
            check($sformatf("vec%0d_data", i), 32'(rd.rsp_data), 32'(exp_q.pop_front()));
            check($sformatf("vec%0d_busy", i), 32'(rd.rsp_busy), 32'(vecs[i].exp_busy));
            finish_rsp($sformatf("vec%0d", i));
        end

        // rsp_ready tied high: one-cycle valid, immediate second request.
        rd.rsp_ready = 1'b1;
        m_hi = 4'h4; m_lo = 4'h1;
        start_req(RS_DATA);
        wait_rsp(1'b0);
        check("b2b_data", 32'(rd.rsp_data), 32'h41);
        check("b2b_busy", 32'(rd.rsp_busy), 32'd0);
        @(negedge sys0_clk);
        check("b2b_valid_one_cycle", 32'(rd.rsp_valid), 32'd0);
        check("b2b_ready_next", 32'(rd.req_ready), 32'd1);
        m_hi = 4'h6; m_lo = 4'h9;
        start_req(RS_DATA);
        wait_rsp(1'b0);
        check("b2b_gap_ge14", 32'(gap_mid >= 14), 32'd1);
        check("b2b2_latency", 32'(lat), 32'(LAT));
        check("b2b2_data", 32'(rd.rsp_data), 32'h69);
        @(negedge sys0_clk);
        check("b2b2_valid_one_cycle", 32'(rd.rsp_valid), 32'd0);
        rd.rsp_ready = 1'b0;

        // Backpressure: response held 500 cycles while requests toggle.
        m_hi = 4'h2; m_lo = 4'hC;
        repeat (2) @(negedge sys0_clk);
        start_req(RS_CMD);
        wait_rsp(1'b0);
        errs = 0;
        for (int i = 0; i < 500; i++) begin
            rd.req_valid = 1'($urandom_range(0, 1));
            rd.req_rs    = 1'($urandom_range(0, 1));
            @(negedge sys0_clk);
            if (rd.rsp_data !== 8'h2C || rd.rsp_valid !== 1'b1 || lcd_e !== 1'b0 ||
                bus_own !== 1'b0 || rd.req_ready !== 1'b0) errs++;
        end
        rd.req_valid = 1'b0;
        check("hold_stable_errs", 32'(errs), 32'd0);
        check("hold_busy", 32'(rd.rsp_busy), 32'd0);
        finish_rsp("hold");
        @(negedge sys0_clk);
        check("hold_no_new_op", 32'(bus_own), 32'd0);

        // Reset in the middle of EL1 aborts cleanly.
        m_hi = 4'h9; m_lo = 4'h6;
        start_req(RS_DATA);
        repeat (100) @(negedge sys0_clk);
        check("abort_in_el1", 32'(dbg_state), 32'(ST_EL1));
        sys0_rstn = 1'b0;
        rises0 = valid_rises;
        @(negedge sys0_clk);
        check("abort_pins", 32'({lcd_e, lcd_rw, bus_own}), 32'd0);
        check("abort_req_ready", 32'(rd.req_ready), 32'd1);
        sys0_rstn = 1'b1;
        repeat (300) @(negedge sys0_clk);
        check("abort_no_rsp", 32'(valid_rises - rises0), 32'd0);
        m_hi = 4'h5; m_lo = 4'hA;
        start_req(RS_CMD);
        wait_rsp(1'b0);
        check("after_abort_data", 32'(rd.rsp_data), 32'h5A);
        check("after_abort_latency", 32'(lat), 32'(LAT));
        finish_rsp("after_abort");

        // Random traffic with random response delays.
        for (int i = 0; i < 4; i++) begin
            rs_r = 1'($urandom_range(0, 1));
            hi_r = 4'($urandom_range(0, 15));
            lo_r = 4'($urandom_range(0, 15));
            m_hi = hi_r; m_lo = lo_r;
            exp_q.push_back({hi_r, lo_r});
            start_req(rs_r);
            wait_rsp(1'b0);
            d = $urandom_range(0, 20);
            repeat (d) @(negedge sys0_clk);
            check($sformatf("rnd%0d_data", i), 32'(rd.rsp_data), 32'(exp_q.pop_front()));
            check($sformatf("rnd%0d_busy", i), 32'(rd.rsp_busy), 32'((rs_r == RS_CMD) ? hi_r[3] : 1'b0));
            finish_rsp($sformatf("rnd%0d", i));
        end

        check("protocol_errs", 32'(proto_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
